// File: rtl/polar_llr_pkg.sv
// Shared types and helpers for the polar LLR frame builder.
//   frame_state_e : frame-builder state, encoded as {pending, credit}
//   llr_condition : negate (saturating) then arithmetic right shift
//   frame_pos     : arrival index -> frame slot, optionally reversed
package polar_llr_pkg;

  localparam int unsigned LLR_CALC_W = 32;

  // Bit 1 is "a complete frame is pending", bit 0 is "decoder credit held".
  typedef enum logic [1:0] {
    ST_FILL_BUSY = 2'b00,
    ST_FILL_IDLE = 2'b01,
    ST_WAIT      = 2'b10,
    ST_READY     = 2'b11
  } frame_state_e;

  // Works on a sign-extended sample; 'bits' gives the real LLR width so the
  // most-negative code saturates to the most-positive one on negation.
  function automatic logic signed [LLR_CALC_W-1:0] llr_condition(
    input logic signed [LLR_CALC_W-1:0] s,
    input int unsigned                  bits,
    input int unsigned                  negate,
    input int unsigned                  shift
  );
    logic signed [LLR_CALC_W-1:0] max_v;
    logic signed [LLR_CALC_W-1:0] min_v;
    logic signed [LLR_CALC_W-1:0] v;
    max_v = $signed(LLR_CALC_W'(1) << (bits - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    v     = s;
    if (negate != 0) begin
      v = (s == min_v) ? max_v : -s;
    end
    return v >>> shift;
  endfunction

  function automatic int unsigned frame_pos(
    input int unsigned i,
    input int unsigned n,
    input int unsigned reverse
  );
    return (reverse != 0) ? (n - 1 - i) : i;
  endfunction

endpackage

// File: rtl/polar_llr_condition.sv
// Combinational conditioning of one channel sample into a decoder LLR.
//   in_sample : signed channel sample
//   out_llr   : negated (if NEGATE) and arithmetically shifted LLR, same width
module polar_llr_condition
  import polar_llr_pkg::*;
#(
  parameter int unsigned BITS   = 8,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned NEGATE = 1
) (
  input  logic signed [BITS-1:0] in_sample,
  output logic signed [BITS-1:0] out_llr
);

  // Size cast of a signed operand sign-extends; result always fits in BITS.
  assign out_llr = BITS'(llr_condition(LLR_CALC_W'(in_sample), BITS, NEGATE, SHIFT));

endmodule

// File: rtl/polar_llr_frame_builder.sv
// Collects N conditioned LLRs into a frame and hands it to polar_decode with a
// single-credit flow control returned by the decoder's out_valid.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid/in_ready/in_sample : serial sample handshake
//   dec_done     : decoder finished, returns the credit
//   out_valid    : one-cycle pulse, y carries a new frame
//   y            : frame LLRs, held until the next issue
//   frame_count  : frames issued, wraps at 2^16
module polar_llr_frame_builder
  import polar_llr_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned BITS    = 8,
  parameter int unsigned SHIFT   = 2,
  parameter int unsigned NEGATE  = 1,
  parameter int unsigned REVERSE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] in_sample,
  input  logic                   dec_done,
  output logic                   out_valid,
  output logic signed [BITS-1:0] y [N],
  output logic [15:0]            frame_count
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = 16;

  frame_state_e           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic signed [BITS-1:0] pend_buf_q [N];
  logic signed [BITS-1:0] pend_buf_d [N];
  logic signed [BITS-1:0] y_q [N];
  logic signed [BITS-1:0] y_d [N];
  logic                   out_valid_q, out_valid_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic signed [BITS-1:0] llr_c;
  logic                   pending_c;
  logic                   accept_c;
  logic                   last_c;

  polar_llr_condition #(
    .BITS   (BITS),
    .SHIFT  (SHIFT),
    .NEGATE (NEGATE)
  ) u_cond (
    .in_sample (in_sample),
    .out_llr   (llr_c)
  );

  assign pending_c = (state_q == ST_WAIT) || (state_q == ST_READY);
  assign in_ready  = !pending_c && !rst;
  assign accept_c  = in_valid && in_ready;
  assign last_c    = (idx_q == IDX_W'(N - 1));

  // Fill, credit and issue decisions; accepts only happen while not pending.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_buf_d  = pend_buf_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;

    if (accept_c) begin
      pend_buf_d[IDX_W'(frame_pos(32'(idx_q), N, REVERSE))] = llr_c;
      idx_d = last_c ? '0 : idx_q + IDX_W'(1);
    end

    case (state_q)
      ST_FILL_IDLE: begin
        if (accept_c && last_c) state_d = ST_READY;
      end
      ST_FILL_BUSY: begin
        if (accept_c && last_c) begin
          state_d = dec_done ? ST_READY : ST_WAIT;
        end else if (dec_done) begin
          state_d = ST_FILL_IDLE;
        end
      end
      ST_WAIT: begin
        if (dec_done) state_d = ST_READY;
      end
      ST_READY: begin
        // Issue: credit is consumed, so a dec_done here cannot occur.
        y_d         = pend_buf_q;
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        state_d     = ST_FILL_BUSY;
      end
      default: state_d = ST_FILL_IDLE;
    endcase
  end

  // State register; reset discards partial and pending frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        pend_buf_q[k] <= '0;
        y_q[k]        <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      pend_buf_q  <= pend_buf_d;
      y_q         <= y_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign frame_count = cnt_q;
  assign y           = y_q;

endmodule

// File: tb/tb_polar_llr_frame_builder.sv
// Two builders share one stimulus stream: A with the default conditioning
// (negate, >>>2, reversed) and B with identity conditioning in arrival order.
module tb_polar_llr_frame_builder;

  localparam int unsigned N    = 4;
  localparam int unsigned BITS = 8;

  logic clk;
  logic rst;
  logic in_valid;
  logic dec_done;
  logic signed [BITS-1:0] in_sample;
  logic rdy_a, rdy_b, ov_a, ov_b;
  logic signed [BITS-1:0] ya [N];
  logic signed [BITS-1:0] yb [N];
  logic [15:0] cnt_a, cnt_b;

  polar_llr_frame_builder #(
    .N(N), .BITS(BITS), .SHIFT(2), .NEGATE(1), .REVERSE(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_sample(in_sample), .dec_done(dec_done), .out_valid(ov_a),
    .y(ya), .frame_count(cnt_a)
  );

  polar_llr_frame_builder #(
    .N(N), .BITS(BITS), .SHIFT(0), .NEGATE(0), .REVERSE(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_sample(in_sample), .dec_done(dec_done), .out_valid(ov_b),
    .y(yb), .frame_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: per-builder parameters and spec-level frame state.
  int p_neg [2] = '{1, 0};
  int p_sh  [2] = '{2, 0};
  int p_rev [2] = '{1, 0};
  bit m_pend [2];
  bit m_cred [2];
  bit m_ov   [2];
  int m_idx  [2];
  int m_cnt  [2];
  int m_buf  [2][N];
  int m_y    [2][N];

  // Negate with saturation, then floor-divide by 2^sh.
  function automatic int cond(input int s, input int neg, input int sh);
    int v;
    int d;
    v = s;
    d = 1 << sh;
    if (neg != 0) v = (s == -128) ? 127 : -s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0;
      m_cred[k] = 1'b1;
      m_ov[k]   = 1'b0;
      m_idx[k]  = 0;
      m_cnt[k]  = 0;
      for (int j = 0; j < N; j++) begin
        m_buf[k][j] = 0;
        m_y[k][j]   = 0;
      end
    end
  endtask

  task automatic model_step(input bit v, input int s, input bit d, input bit r);
    bit issue;
    bit acc;
    int pos;
    if (r) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      issue    = m_pend[k] && m_cred[k];
      acc      = v && !m_pend[k];
      m_ov[k]  = issue;
      if (issue) begin
        for (int j = 0; j < N; j++) m_y[k][j] = m_buf[k][j];
        m_cnt[k]  = (m_cnt[k] + 1) % 65536;
        m_pend[k] = 1'b0;
        m_cred[k] = 1'b0;
      end else if (d) begin
        m_cred[k] = 1'b1;
      end
      if (acc) begin
        pos = (p_rev[k] != 0) ? (N - 1 - m_idx[k]) : m_idx[k];
        m_buf[k][pos] = cond(s, p_neg[k], p_sh[k]);
        if (m_idx[k] == N - 1) begin
          m_pend[k] = 1'b1;
          m_idx[k]  = 0;
        end else begin
          m_idx[k]++;
        end
      end
    end
  endtask

  // One clock: drive, check in_ready, advance model, check registered outputs.
  task automatic cycle(input bit v, input int s, input bit d, input bit r);
    in_valid  = v;
    in_sample = BITS'(s);
    dec_done  = d;
    rst       = r;
    #1;
    check("A in_ready", {31'b0, rdy_a}, {31'b0, !m_pend[0] && !r});
    check("B in_ready", {31'b0, rdy_b}, {31'b0, !m_pend[1] && !r});
    model_step(v, s, d, r);
    @(posedge clk);
    #1;
    check("A out_valid", {31'b0, ov_a}, {31'b0, m_ov[0]});
    check("B out_valid", {31'b0, ov_b}, {31'b0, m_ov[1]});
    check("A frame_count", 32'(cnt_a), m_cnt[0]);
    check("B frame_count", 32'(cnt_b), m_cnt[1]);
    for (int j = 0; j < N; j++) begin
      check($sformatf("A y[%0d]", j), 32'(ya[j]), m_y[0][j]);
      check($sformatf("B y[%0d]", j), 32'(yb[j]), m_y[1][j]);
    end
  endtask

  task automatic check_y(input string tag, input bit which,
                         input int e0, input int e1, input int e2, input int e3);
    int e [N];
    e = '{e0, e1, e2, e3};
    for (int j = 0; j < N; j++) begin
      check($sformatf("%s y[%0d]", tag, j), which ? 32'(yb[j]) : 32'(ya[j]), e[j]);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_sample = '0;
    dec_done  = 1'b0;
    rst       = 1'b1;
    model_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("reset count", 32'(cnt_a), 0);

    // Basic frame and pulse timing
    cycle(1, 40, 0, 0);
    cycle(1, -40, 0, 0);
    cycle(1, 40, 0, 0);
    cycle(1, -40, 0, 0);
    check("basic ov at E0", {31'b0, ov_a}, 0);
    cycle(0, 0, 0, 0);
    check("basic ov at E1", {31'b0, ov_a}, 1);
    check_y("basic", 0, 10, -10, 10, -10);
    check("basic count", 32'(cnt_a), 1);
    cycle(0, 0, 0, 0);
    check("basic ov at E2", {31'b0, ov_a}, 0);

    // Saturation and floor
    cycle(0, 0, 1, 0);
    cycle(1, -128, 0, 0);
    cycle(1, 127, 0, 0);
    cycle(1, -1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check_y("sat", 0, -1, 0, -32, 31);
    check_y("sat B", 1, -128, 127, -1, 1);

    // Backpressure
    cycle(0, 0, 1, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 8, 0, 0);
    cycle(1, 12, 0, 0);
    cycle(1, 16, 0, 0);
    cycle(0, 0, 0, 0);
    check_y("bp A", 0, -4, -3, -2, -1);
    cycle(1, 100, 0, 0);
    cycle(1, -100, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 8, 0, 0);
    check("bp ready low", {31'b0, rdy_a}, 0);
    for (int i = 0; i < 3; i++) cycle(1, 99, 0, 0);
    check_y("bp hold", 0, -4, -3, -2, -1);
    cycle(1, 99, 1, 0);
    check("bp ov at Ed", {31'b0, ov_a}, 0);
    cycle(0, 0, 0, 0);
    check("bp ov after Ed+1", {31'b0, ov_a}, 1);
    check_y("bp B", 0, -2, 0, 25, -25);
    check("bp count", 32'(cnt_a), 4);

    // Reset mid-frame
    cycle(1, 4, 0, 0);
    cycle(1, 8, 0, 0);
    cycle(0, 0, 0, 1);
    check("rst ov", {31'b0, ov_a}, 0);
    check_y("rst", 0, 0, 0, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 8, 0, 0);
    cycle(1, 12, 0, 0);
    cycle(1, 16, 0, 0);
    cycle(0, 0, 0, 0);
    check_y("post rst", 0, -4, -3, -2, -1);
    check("post rst count", 32'(cnt_a), 1);

    // Redundant dec_done, then gaps and forward order
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check("extra done ov", {31'b0, ov_a}, 0);
    check("extra done count", 32'(cnt_a), 1);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 2, 0, 0);
    cycle(1, 3, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(0, 0, 0, 0);
    check_y("gaps B", 1, 1, 2, 3, 4);
    check_y("gaps A", 0, -1, -1, -1, -1);
    check("gaps count B", 32'(cnt_b), 2);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7,
            int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
